// File: rtl/bus_watch_monitor.sv
// Bus tap: halt/timeout detection plus capture of MMIO-window writes into a log FIFO.
// Latency: flags and counters are registered (visible 1 cycle after the edge); a log entry is visible 1 cycle after its push.
// Backpressure: log_ready stalls the drain; window writes arriving while the log is full and not popping are dropped and counted.

module bus_watch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push_vld,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop_rdy,
    output logic                     pop_vld,
    output logic [W-1:0]             pop_dat,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full
);
    localparam int PW    = $clog2(DEPTH);
    localparam int PTR_W = PW + 1;

    // The extra pointer bit separates full (pointers differ by DEPTH) from empty.
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [W-1:0]     mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == PTR_W'(DEPTH));
    assign pop_vld = (wr_ptr != rd_ptr);
    assign pop_dat = mem[rd_ptr[PW-1:0]];
    assign do_pop  = pop_rdy && pop_vld;
    // A pop on the same edge frees the slot the push needs, so full does not block it.
    assign do_push = push_vld && (!full || do_pop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= push_dat;
    end
endmodule

module bus_watch_monitor #(
    parameter int                 ADDR_W      = 32,
    parameter int                 DATA_W      = 32,
    parameter logic [ADDR_W-1:0]  HALT_ADDR   = 32'hFFC,
    parameter logic [ADDR_W-1:0]  WIN_BASE    = 32'h800,
    parameter logic [ADDR_W-1:0]  WIN_MASK    = 32'h800,
    parameter int                 LOG_DEPTH   = 8,
    parameter int                 TIMEOUT_CYC = 2000,
    parameter int                 CNT_W       = 16
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [ADDR_W-1:0]            address,
    input  logic [DATA_W-1:0]            data_out,
    input  logic                         we,
    output logic                         halted,
    output logic                         timed_out,
    output logic                         done,
    output logic [CNT_W-1:0]             cycle_cnt,
    output logic                         log_valid,
    input  logic                         log_ready,
    output logic [ADDR_W-1:0]            log_addr,
    output logic [DATA_W-1:0]            log_data,
    output logic [$clog2(LOG_DEPTH):0]   log_level,
    output logic [CNT_W-1:0]             drop_cnt
);
    typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_TIMEOUT} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } log_ent_t;

    state_t   state;
    log_ent_t cap_ent;
    log_ent_t head_ent;
    logic     halt_hit;
    logic     win_hit;
    logic     to_hit;
    logic     cap_vld;
    logic     fifo_full;
    logic     drop;

    assign halt_hit = (address == HALT_ADDR);
    assign win_hit  = ((address & WIN_MASK) == WIN_BASE);
    assign to_hit   = (TIMEOUT_CYC != 0) && (cycle_cnt == CNT_W'(TIMEOUT_CYC - 1));
    // The halting edge is still RUN, so a window write on it is captured.
    assign cap_vld  = (state == ST_RUN) && we && win_hit;
    assign drop     = cap_vld && fifo_full && !(log_valid && log_ready);
    assign cap_ent  = '{addr: address, data: data_out};
    assign log_addr = head_ent.addr;
    assign log_data = head_ent.data;

    bus_watch_fifo #(
        .W     ($bits(log_ent_t)),
        .DEPTH (LOG_DEPTH)
    ) u_log_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push_vld (cap_vld),
        .push_dat (cap_ent),
        .pop_rdy  (log_ready),
        .pop_vld  (log_valid),
        .pop_dat  (head_ent),
        .level    (log_level),
        .full     (fifo_full)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_RUN;
            halted    <= 1'b0;
            timed_out <= 1'b0;
            done      <= 1'b0;
            cycle_cnt <= '0;
        end else if (state == ST_RUN) begin
            if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNT_W'(1);
            // Halt has priority over a timeout expiring on the same edge.
            if (halt_hit) begin
                state  <= ST_HALT;
                halted <= 1'b1;
                done   <= 1'b1;
            end else if (to_hit) begin
                state     <= ST_TIMEOUT;
                timed_out <= 1'b1;
                done      <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drop_cnt <= '0;
        end else if (drop && drop_cnt != '1) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_bus_watch_monitor.sv
// Bench: two monitors (timeout 2000 and 16) share one bus; both are checked every cycle against a queue-based model.
module tb_bus_watch_monitor;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] data_out = '0;
    logic        we = 1'b0;
    logic        log_ready = 1'b0;

    logic [1:0]  halted_w, timed_w, done_w, lvalid_w;
    logic [15:0] cnt_w  [2];
    logic [15:0] drop_w [2];
    logic [31:0] la_w   [2];
    logic [31:0] ld_w   [2];
    logic [3:0]  lvl_w  [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bus_watch_monitor dut (
        .clk(clk), .resetn(resetn), .address(address), .data_out(data_out), .we(we),
        .halted(halted_w[0]), .timed_out(timed_w[0]), .done(done_w[0]), .cycle_cnt(cnt_w[0]),
        .log_valid(lvalid_w[0]), .log_ready(log_ready), .log_addr(la_w[0]), .log_data(ld_w[0]),
        .log_level(lvl_w[0]), .drop_cnt(drop_w[0])
    );

    bus_watch_monitor #(.TIMEOUT_CYC(16)) dut_to (
        .clk(clk), .resetn(resetn), .address(address), .data_out(data_out), .we(we),
        .halted(halted_w[1]), .timed_out(timed_w[1]), .done(done_w[1]), .cycle_cnt(cnt_w[1]),
        .log_valid(lvalid_w[1]), .log_ready(log_ready), .log_addr(la_w[1]), .log_data(ld_w[1]),
        .log_level(lvl_w[1]), .drop_cnt(drop_w[1])
    );

    // Model: 0=running, 1=halted, 2=timed out; the log is a plain queue of {addr,data}.
    int          m_st   [2];
    int unsigned m_cnt  [2];
    int unsigned m_drop [2];
    logic [63:0] mq     [2][$];

    function automatic int unsigned to_of(input int i);
        return (i == 0) ? 2000 : 16;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0;
            m_cnt[i] = 0;
            m_drop[i] = 0;
            mq[i].delete();
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit pop;
            bit hit;
            pop = log_ready && (mq[i].size() > 0);
            hit = (m_st[i] == 0) && we && ((address & 32'h800) == 32'h800);
            if (pop) void'(mq[i].pop_front());
            if (hit) begin
                if (mq[i].size() < 8) mq[i].push_back({address, data_out});
                else if (m_drop[i] < 65535) m_drop[i]++;
            end
            if (m_st[i] == 0) begin
                if (address == 32'hFFC) m_st[i] = 1;
                else if (to_of(i) != 0 && m_cnt[i] == to_of(i) - 1) m_st[i] = 2;
                if (m_cnt[i] < 65535) m_cnt[i]++;
            end
        end
    endtask

    task automatic compare();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("halted[%0d]", i),    64'(halted_w[i]), 64'(m_st[i] == 1));
            chk($sformatf("timed_out[%0d]", i), 64'(timed_w[i]),  64'(m_st[i] == 2));
            chk($sformatf("done[%0d]", i),      64'(done_w[i]),   64'(m_st[i] != 0));
            chk($sformatf("cycle_cnt[%0d]", i), 64'(cnt_w[i]),    64'(m_cnt[i]));
            chk($sformatf("drop_cnt[%0d]", i),  64'(drop_w[i]),   64'(m_drop[i]));
            chk($sformatf("log_level[%0d]", i), 64'(lvl_w[i]),    64'(mq[i].size()));
            chk($sformatf("log_valid[%0d]", i), 64'(lvalid_w[i]), 64'(mq[i].size() > 0));
            if (mq[i].size() > 0)
                chk($sformatf("log_head[%0d]", i), {la_w[i], ld_w[i]}, mq[i][0]);
        end
    endtask

    task automatic tick(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
        address = a;
        data_out = d;
        we = w;
        log_ready = r;
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        address = '0;
        data_out = '0;
        we = 1'b0;
        log_ready = 1'b0;
        model_reset();
        repeat (5) @(posedge clk);
        #1;
        compare();
        resetn = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        int unsigned frozen;

        // Reset state and free-running cycle count.
        do_reset();
        chk("rst_done", 64'(done_w), 64'd0);
        chk("rst_lvalid", 64'(lvalid_w), 64'd0);
        for (int k = 1; k <= 3; k++) begin
            tick(32'h0, 32'h0, 1'b0, 1'b0);
            chk($sformatf("cnt_step%0d", k), 64'(cnt_w[0]), 64'(k));
        end

        // Window filtering and ordering.
        tick(32'h805, 32'h11, 1'b1, 1'b1);
        chk("t2_head1", {la_w[0], ld_w[0]}, {32'h805, 32'h11});
        tick(32'h100, 32'h22, 1'b1, 1'b1);
        chk("t2_empty", 64'(lvl_w[0]), 64'd0);
        tick(32'hFF0, 32'h33, 1'b1, 1'b1);
        chk("t2_head2", {la_w[0], ld_w[0]}, {32'hFF0, 32'h33});
        tick(32'h0, 32'h0, 1'b0, 1'b1);
        chk("t2_drop", 64'(drop_w[0]), 64'd0);

        // Overflow, then simultaneous push and pop while full.
        for (int k = 0; k < 10; k++) tick(32'h800 + k, k, 1'b1, 1'b0);
        chk("t3_level", 64'(lvl_w[0]), 64'd8);
        chk("t3_drop", 64'(drop_w[0]), 64'd2);
        chk("t3_head", {la_w[0], ld_w[0]}, {32'h800, 32'h0});
        tick(32'h8AA, 32'hAA, 1'b1, 1'b1);
        chk("t4_level", 64'(lvl_w[0]), 64'd8);
        chk("t4_drop", 64'(drop_w[0]), 64'd2);
        chk("t4_head", {la_w[0], ld_w[0]}, {32'h801, 32'h1});
        for (int k = 0; k < 7; k++) tick(32'h0, 32'h0, 1'b0, 1'b1);
        chk("t4_last", {la_w[0], ld_w[0]}, {32'h8AA, 32'hAA});
        tick(32'h0, 32'h0, 1'b0, 1'b1);

        // Halting write is logged; later writes are ignored; drain continues.
        do_reset();
        tick(32'hFFC, 32'hDEAD, 1'b1, 1'b0);
        chk("t5_halted", 64'(halted_w[0]), 64'd1);
        chk("t5_entry", {la_w[0], ld_w[0]}, {32'hFFC, 32'hDEAD});
        frozen = cnt_w[0];
        for (int k = 0; k < 3; k++) tick(32'h900 + k, k, 1'b1, 1'b0);
        chk("t5_level", 64'(lvl_w[0]), 64'd1);
        chk("t5_frozen", 64'(cnt_w[0]), 64'(frozen));
        tick(32'h900, 32'h5, 1'b1, 1'b1);
        chk("t5_drained", 64'(lvalid_w[0]), 64'd0);

        // Timeout after 16 cycles in the short-budget instance.
        do_reset();
        for (int k = 0; k < 15; k++) tick(32'h0, 32'h0, 1'b0, 1'b0);
        chk("t6_not_yet", 64'(timed_w[1]), 64'd0);
        tick(32'h0, 32'h0, 1'b0, 1'b0);
        chk("t6_timed_out", 64'(timed_w[1]), 64'd1);
        chk("t6_cnt", 64'(cnt_w[1]), 64'd16);
        tick(32'h0, 32'h0, 1'b0, 1'b0);
        chk("t6_cnt_frozen", 64'(cnt_w[1]), 64'd16);

        // Halt on the same edge the timeout would fire: halt wins.
        do_reset();
        for (int k = 0; k < 15; k++) tick(32'h0, 32'h0, 1'b0, 1'b0);
        tick(32'hFFC, 32'h0, 1'b0, 1'b0);
        chk("t6b_halted", 64'(halted_w[1]), 64'd1);
        chk("t6b_timed_out", 64'(timed_w[1]), 64'd0);

        // Reset in the middle of logging.
        do_reset();
        for (int k = 0; k < 4; k++) tick(32'h840 + k, 32'h70 + k, 1'b1, 1'b0);
        do_reset();
        chk("t6c_lvalid", 64'(lvalid_w[0]), 64'd0);
        chk("t6c_level", 64'(lvl_w[0]), 64'd0);
        chk("t6c_cnt", 64'(cnt_w[0]), 64'd0);

        // Default 2000-cycle budget.
        for (int k = 0; k < 1999; k++) tick(32'h0, 32'h0, 1'b0, 1'b0);
        chk("to2000_not_yet", 64'(timed_w[0]), 64'd0);
        tick(32'h0, 32'h0, 1'b0, 1'b0);
        chk("to2000_timed_out", 64'(timed_w[0]), 64'd1);

        // Randomized traffic; odd rounds starve the consumer to exercise overflow.
        for (int round = 0; round < 8; round++) begin
            do_reset();
            for (int k = 0; k < 250; k++) begin
                int unsigned sel;
                sel = $urandom_range(0, 99);
                if (sel < 55) begin
                    a = $urandom | 32'h800;
                    if (a == 32'hFFC) a = 32'h800;
                end else if (sel < 99) begin
                    a = $urandom & ~32'h800;
                end else begin
                    a = 32'hFFC;
                end
                tick(a, $urandom, ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 3) < ((round % 2) ? 1 : 3)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
